s1423_state_seq: RTL and testbench
==================================

Name: s1423_state_seq

Overview:
- Sequential state stage directly upstream of the s1423 n85 next-state cone.
- Holds the registered state bits that the cone reads:
  - the 5-bit operand register (G74..G78 / G0..G4 select path);
  - the 5-bit accumulator (G42..G46);
  - the 7-bit chain register (G24..G30).
- Captures the cone's n85 result back into chain bit 6 (G30).
- Provides a full scan chain and a start/done run handshake for bench-driven evaluation.

Parameters:
- RUN_CYCLES, 16, functional update cycles per START request (legal 1..255).
- ACC_W, 5, accumulator and operand width (fixed 5 for s1423 mapping).
- CHAIN_W, 7, chain register width (G24..G30).

Ports:
- CK  in  1  clock, all flops rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  pulse; begins a run when idle.
- SEL  in  1  operand select (G90): 1 = ALT, 0 = PI.
- PI  in  5  primary operand G0..G4 (bit0 = G0).
- ALT  in  5  alternate operand G74..G78 (bit0 = G74).
- N85_IN  in  1  next-state bit returned from the n85 cone.
- SCAN_EN  in  1  scan shift enable.
- SCAN_IN  in  1  scan serial input.
- OPQ  out  5  registered operand.
- ACC_Q  out  5  accumulator, bit0 = G42 .. bit4 = G46.
- CHAIN_Q  out  7  chain, bit0 = G24 .. bit6 = G30.
- BUSY  out  1  high in LOAD/RUN.
- DONE  out  1  one-cycle pulse at run end.
- SCAN_OUT  out  1  = CHAIN_Q[6].

Behaviour:
- Reset (RST=1 at a CK edge):
  - OPQ, ACC_Q, CHAIN_Q, BUSY, DONE all go to 0.
  - FSM goes to IDLE and the cycle counter goes to 0.
  - Reset overrides scan and START. A mid-run reset aborts the run with no DONE pulse.
- FSM states: IDLE, LOAD, RUN, FIN.
  - IDLE:
    - START=1 and SCAN_EN=0 -> LOAD.
    - START while SCAN_EN=1 is ignored.
  - LOAD (1 cycle):
    - OPQ <= SEL ? ALT : PI.
    - Counter <= 0.
    - Go to RUN.
  - RUN, each cycle:
    - {carry, ACC_Q} <= ACC_Q + OPQ. The 6-bit sum wraps mod 32; carry is the sum's bit 5.
    - If carry=1, CHAIN_Q[5:0] increments, saturating at 63.
    - CHAIN_Q[6] <= N85_IN.
    - OPQ reloads from the SEL mux every cycle.
    - Counter increments.
    - After the RUN_CYCLES-th update -> FIN.
  - FIN:
    - DONE=1 for exactly this cycle; state frozen.
    - Go to IDLE.
    - A START in FIN is ignored.
- BUSY = 1 in LOAD and RUN, registered with the state. START while BUSY is ignored (no queueing).
- Scan:
  - SCAN_EN=1 in IDLE or FIN shifts the 17-bit chain one position per cycle. Order: SCAN_IN -> OPQ[0] .. OPQ[4] -> ACC_Q[0] .. ACC_Q[4] -> CHAIN_Q[0] .. CHAIN_Q[6] -> SCAN_OUT.
  - SCAN_EN=1 in LOAD or RUN freezes all state and the counter for that cycle (run pauses). Functional update resumes when SCAN_EN drops.
- Outputs are direct flop outputs; the cone sees new state one cycle after the update edge.
- Latency from START to DONE = RUN_CYCLES + 2 cycles, excluding scan pauses.

Decomposition:
- Shared package s1423_pkg holds:
  - the FSM state enum;
  - ACC_W and CHAIN_W constants;
  - SCAN_LEN = ACC_W*2 + CHAIN_W;
  - the G-index bit mapping constants.
- One natural sub-module, s1423_acc_chain: the accumulator add plus saturating chain counter datapath, with enable and scan-freeze inputs. The FSM and scan muxing stay in the top.

Test Plan:
- Reset then idle: RST high 2 cycles -> all outputs 0, BUSY=0. With START=0 for 10 cycles, state remains 0.
- SEL=0, PI=5'd7, RUN_CYCLES=16, N85_IN=0, START pulse:
  - Accumulator steps 7, 14, 21, 28, 3 (carry), ...; ACC_Q ends at 16*7 mod 32 = 16.
  - Carries occur at updates 5, 10, 14 -> CHAIN_Q[5:0]=3 at DONE.
  - DONE at cycle 18 after START.
- SEL=1, ALT=5'd31, 70 back-to-back runs of 16 cycles -> CHAIN_Q[5:0] saturates at 63 and never wraps to 0.
- N85_IN toggling 1,0,1 during RUN -> CHAIN_Q[6]/SCAN_OUT follows with one-cycle delay.
- Scan: load pattern 17'h1A5C3 via 17 SCAN_EN cycles in IDLE -> outputs match the mapped bits. A further 17 shifts return the pattern on SCAN_OUT, MSB (CHAIN_Q[6]) first.
- Assert RST at RUN cycle 5 -> state 0 next edge, no DONE pulse. START one cycle later is accepted (BUSY=1 next cycle).

Source files
------------

// File: rtl/s1423_pkg.sv
// Shared types and constants for the s1423 state stage feeding the n85 cone.
// Bit maps tie each register bit back to its G-net name in the s1423 netlist.
package s1423_pkg;

    localparam int ACC_W    = 5;
    localparam int CHAIN_W  = 7;
    localparam int SCAN_LEN = ACC_W * 2 + CHAIN_W;
    localparam int CNT_W    = 8;
    localparam int SAT_W    = CHAIN_W - 1;

    // G-index of bit 0 of each register; bit i maps to G(base + i)
    localparam int G_PI_BASE    = 0;
    localparam int G_ALT_BASE   = 74;
    localparam int G_ACC_BASE   = 42;
    localparam int G_CHAIN_BASE = 24;
    localparam int G_SEL        = 90;
    localparam int CHAIN_N85_BIT = CHAIN_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } seq_state_t;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/s1423_state_seq_if.sv
// Operand, handshake, scan and state-observation signals of the s1423 state stage.
// master drives the stimulus side, slave is the sequencer itself.
interface s1423_state_seq_if;
    import s1423_pkg::*;

    logic               start;
    logic               sel;
    logic [ACC_W-1:0]   pi;
    logic [ACC_W-1:0]   alt;
    logic               n85_in;
    logic               scan_en;
    logic               scan_in;
    logic [ACC_W-1:0]   opq;
    logic [ACC_W-1:0]   acc_q;
    logic [CHAIN_W-1:0] chain_q;
    logic               busy;
    logic               done;
    logic               scan_out;

    modport master (
        output start, sel, pi, alt, n85_in, scan_en, scan_in,
        input  opq, acc_q, chain_q, busy, done, scan_out
    );

    modport slave (
        input  start, sel, pi, alt, n85_in, scan_en, scan_in,
        output opq, acc_q, chain_q, busy, done, scan_out
    );

endinterface

// File: rtl/s1423_acc_chain.sv
// Accumulator (G42..G46) plus chain register (G24..G30): carry-driven saturating
// count in bits 5:0 and the captured n85 cone result in bit 6.
module s1423_acc_chain
    import s1423_pkg::*;
(
    input  logic               ck,
    input  logic               rst,
    input  logic               upd_en,
    input  logic               freeze,
    input  logic               shift_en,
    input  logic               shift_in,
    input  logic [ACC_W-1:0]   opq,
    input  logic               n85_in,
    output logic [ACC_W-1:0]   acc_q,
    output logic [CHAIN_W-1:0] chain_q
);

    logic [ACC_W:0] sum;

    assign sum = {1'b0, acc_q} + {1'b0, opq};

    // Scan shifts acc then chain as one segment: shift_in enters acc_q[0]
    always_ff @(posedge ck) begin
        if (rst) begin
            acc_q   <= '0;
            chain_q <= '0;
        end else if (!freeze) begin
            if (shift_en) begin
                {chain_q, acc_q} <= {chain_q[CHAIN_W-2:0], acc_q, shift_in};
            end else if (upd_en) begin
                acc_q                  <= sum[ACC_W-1:0];
                chain_q[CHAIN_N85_BIT] <= n85_in;
                if (sum[ACC_W]) begin
                    chain_q[SAT_W-1:0] <= sat_inc(chain_q[SAT_W-1:0]);
                end
            end
        end
    end

endmodule

// File: rtl/s1423_state_seq.sv
// Run sequencer and scan control for the s1423 n85 next-state state stage.
//   state | meaning
//   IDLE  | waiting for START; scan may shift
//   LOAD  | capture operand, clear cycle counter
//   RUN   | one accumulator/chain update per cycle, RUN_CYCLES times
//   FIN   | DONE pulse, state frozen; scan may shift
module s1423_state_seq
    import s1423_pkg::*;
#(
    parameter int RUN_CYCLES = 16
) (
    input  logic               ck,
    input  logic               rst,
    s1423_state_seq_if.slave   bus
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             load_op;
    logic             upd;
    logic             active;
    logic             freeze;
    logic             shift;
    logic [ACC_W-1:0] opnd_mux;
    logic [ACC_W-1:0] opq_q;
    logic             busy_q;
    logic             done_q;

    assign active   = (state == ST_LOAD) || (state == ST_RUN);
    assign freeze   = bus.scan_en & active;
    assign shift    = bus.scan_en & ~active;
    assign opnd_mux = bus.sel ? bus.alt : bus.pi;

    always_ff @(posedge ck) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy_q <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
            done_q <= (state_nxt == ST_FIN);
        end
    end

    // A scan cycle during LOAD/RUN holds the state and counter, pausing the run
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_op   = 1'b0;
        upd       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.scan_en) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!bus.scan_en) begin
                    load_op   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.scan_en) begin
                    upd     = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_W'(RUN_CYCLES - 1)) begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand register is the head of the scan chain: scan_in enters opq[0]
    always_ff @(posedge ck) begin
        if (rst) begin
            opq_q <= '0;
        end else if (shift) begin
            opq_q <= {opq_q[ACC_W-2:0], bus.scan_in};
        end else if (load_op || upd) begin
            opq_q <= opnd_mux;
        end
    end

    s1423_acc_chain u_acc_chain (
        .ck       (ck),
        .rst      (rst),
        .upd_en   (upd),
        .freeze   (freeze),
        .shift_en (shift),
        .shift_in (opq_q[ACC_W-1]),
        .opq      (opq_q),
        .n85_in   (bus.n85_in),
        .acc_q    (bus.acc_q),
        .chain_q  (bus.chain_q)
    );

    assign bus.opq      = opq_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.scan_out = bus.chain_q[CHAIN_W-1];

endmodule

// File: tb/tb_s1423_state_seq.sv
// Bench for s1423_state_seq: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of runs, carries, saturation and scan.
module tb_s1423_state_seq;
    import s1423_pkg::*;

    localparam int RUN_CYCLES = 16;

    logic ck = 1'b0;
    logic rst = 1'b1;
    always #5 ck = ~ck;

    s1423_state_seq_if bus();

    s1423_state_seq #(.RUN_CYCLES(RUN_CYCLES)) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model: plain integers, a pending-load flag and a count of updates left
    int m_op, m_acc, m_ch, m_c6, m_left;
    bit m_loadpend, m_fin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int mux;
        int s;
        bit was_fin;
        logic [16:0] v;
        mux = bus.sel ? int'(bus.alt) : int'(bus.pi);
        if (rst) begin
            m_op = 0; m_acc = 0; m_ch = 0; m_c6 = 0; m_left = 0;
            m_loadpend = 0; m_fin = 0;
        end else if ((m_loadpend || m_left > 0) && bus.scan_en) begin
            m_fin = 0;
        end else if (m_loadpend) begin
            m_op = mux;
            m_left = RUN_CYCLES;
            m_loadpend = 0;
        end else if (m_left > 0) begin
            s = m_acc + m_op;
            if (s >= 32 && m_ch < 63) m_ch++;
            m_acc = s % 32;
            m_c6 = int'(bus.n85_in);
            m_op = mux;
            m_left--;
            m_fin = (m_left == 0);
        end else begin
            was_fin = m_fin;
            m_fin = 0;
            if (bus.scan_en) begin
                v = {m_c6[0], m_ch[5:0], m_acc[4:0], m_op[4:0]};
                v = {v[15:0], bus.scan_in};
                m_op = int'(v[4:0]);
                m_acc = int'(v[9:5]);
                m_ch = int'(v[15:10]);
                m_c6 = int'(v[16]);
            end else if (!was_fin && bus.start) begin
                m_loadpend = 1;
            end
        end
    endtask

    task automatic cmp_all();
        check("opq", 32'(bus.opq), 32'(m_op));
        check("acc_q", 32'(bus.acc_q), 32'(m_acc));
        check("chain_q", 32'(bus.chain_q), 32'((m_c6 << 6) | m_ch));
        check("busy", 32'(bus.busy), 32'(m_loadpend || m_left > 0));
        check("done", 32'(bus.done), 32'(m_fin));
        check("scan_out", 32'(bus.scan_out), 32'(m_c6));
    endtask

    task automatic tick();
        @(posedge ck);
        model_step();
        @(negedge ck);
        cmp_all();
    endtask

    // START pulse then wait for DONE; lat counts ticks from the START edge
    task automatic run_one(input string tag, output int lat);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    initial begin
        int lat;
        int prev_low;
        int wrapped;
        logic [16:0] pat;

        bus.start = 0; bus.sel = 0; bus.pi = 0; bus.alt = 0;
        bus.n85_in = 0; bus.scan_en = 0; bus.scan_in = 0;

        // reset and idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_opq", 32'(bus.opq), 0);
        check("rst_acc", 32'(bus.acc_q), 0);
        check("rst_chain", 32'(bus.chain_q), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        for (int i = 0; i < 10; i++) tick();
        check("idle_state", 32'({bus.opq, bus.acc_q, bus.chain_q, bus.busy}), 0);

        // PI = 7 run: carries at updates 5, 10, 14
        bus.sel = 1'b0; bus.pi = 5'd7;
        run_one("pi7", lat);
        check("pi7_latency", 32'(lat), 32'd18);
        check("pi7_acc", 32'(bus.acc_q), 32'd16);
        check("pi7_chain_cnt", 32'(bus.chain_q[5:0]), 32'd3);
        tick();
        check("pi7_done_pulse", 32'(bus.done), 0);

        // n85 capture follows with one-cycle delay
        bus.pi = 5'd1;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        bus.n85_in = 1'b1; tick();
        check("n85_a", 32'(bus.scan_out), 1);
        bus.n85_in = 1'b0; tick();
        check("n85_b", 32'(bus.chain_q[6]), 0);
        bus.n85_in = 1'b1; tick();
        check("n85_c", 32'(bus.scan_out), 1);
        lat = 0;
        while (!bus.done && lat < 40) begin tick(); lat++; end
        check("n85_done_seen", 32'(bus.done), 1);
        tick();

        // saturation with ALT = 31
        bus.sel = 1'b1; bus.alt = 5'd31;
        prev_low = int'(bus.chain_q[5:0]);
        wrapped = 0;
        for (int r = 0; r < 70; r++) begin
            run_one("sat", lat);
            if (int'(bus.chain_q[5:0]) < prev_low) wrapped++;
            prev_low = int'(bus.chain_q[5:0]);
            tick();
        end
        check("sat_value", 32'(bus.chain_q[5:0]), 32'd63);
        check("sat_no_wrap", 32'(wrapped), 0);

        // scan load and unload
        rst = 1'b1; tick(); rst = 1'b0;
        pat = 17'h1A5C3;
        bus.scan_en = 1'b1;
        for (int i = 0; i < SCAN_LEN; i++) begin
            bus.scan_in = pat[16-i];
            tick();
        end
        check("scan_opq", 32'(bus.opq), 32'(pat[4:0]));
        check("scan_acc", 32'(bus.acc_q), 32'(pat[9:5]));
        check("scan_chain", 32'(bus.chain_q), 32'(pat[16:10]));
        for (int i = 0; i < SCAN_LEN; i++) begin
            check("scan_unload", 32'(bus.scan_out), 32'(pat[16-i]));
            bus.scan_in = 1'b0;
            tick();
        end
        bus.scan_en = 1'b0;

        // mid-run reset at RUN cycle 5, then a fresh start
        bus.sel = 1'b0; bus.pi = 5'd3;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_state", 32'({bus.opq, bus.acc_q, bus.chain_q, bus.busy}), 0);
        check("abort_done", 32'(bus.done), 0);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("restart_busy", 32'(bus.busy), 1);
        lat = 0;
        while (!bus.done && lat < 40) begin tick(); lat++; end
        check("restart_done_seen", 32'(bus.done), 1);

        // random traffic including scan pauses and resets
        for (int c = 0; c < 1500; c++) begin
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.scan_en = ($urandom_range(0, 7) == 0);
            bus.scan_in = 1'($urandom);
            bus.sel     = 1'($urandom);
            bus.pi      = 5'($urandom);
            bus.alt     = 5'($urandom);
            bus.n85_in  = 1'($urandom);
            rst         = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
